// File: rtl/l1_trigger_pkg.sv
// Shared widths, event record layout and dead-time FSM encoding for the L1 readout path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package l1_trigger_pkg;

  localparam int SAMPLE_W = 8;
  localparam int BX_W     = 16;
  localparam int DROP_W   = 8;
  localparam int ACC_W    = 16;
  localparam int DEAD_W   = 8;

  // One captured event, bx in the top bits so raw FIFO words sort by crossing.
  typedef struct packed {
    logic        [BX_W-1:0]     bx;
    logic signed [SAMPLE_W-1:0] energy;
    logic signed [SAMPLE_W-1:0] isol;
  } event_t;

  localparam int EVENT_W = $bits(event_t);

  typedef enum logic {
    ARMED = 1'b0,
    DEAD  = 1'b1
  } state_t;

  // Saturating increment for the drop counter; sticks at all-ones.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through FIFO with full/empty flags.
// Latency: a word written at edge e is visible on rd_dat in the cycle after e.
// Backpressure: writes are dropped while full (even with a same-cycle read); reads while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Extra pointer bit tells full from empty when the index bits match.
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty  = (wr_ptr == rd_ptr);
  assign do_wr  = wr_vld & ~full;
  assign do_rd  = rd_rdy & ~empty;
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  // Pointer and storage update; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr[AW-1:0]] <= wr_dat;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/l1_readout_capture.sv
// Aligns raw per-crossing samples to the L1 decision and captures accepted triggers into an event FIFO.
// Latency: trigger in cycle t pushes at the edge ending t; event valid on out_* in cycle t+1.
// Backpressure: out_valid/out_ready drain; a trigger arriving with the FIFO full is dropped and counted.
module l1_readout_capture
  import l1_trigger_pkg::*;
#(
  parameter int TRIG_LATENCY = 3,
  parameter int DEAD_CYCLES  = 4,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] energy,
  input  logic signed [SAMPLE_W-1:0] isol,
  input  logic                       trigger,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic        [BX_W-1:0]     out_bx,
  output logic signed [SAMPLE_W-1:0] out_energy,
  output logic signed [SAMPLE_W-1:0] out_isol,
  output logic                       busy,
  output logic                       overflow,
  output logic        [ACC_W-1:0]    accept_count,
  output logic        [DROP_W-1:0]   drop_count
);

  logic        [BX_W-1:0]     bx;
  logic        [BX_W-1:0]     bx_dly [TRIG_LATENCY];
  logic signed [SAMPLE_W-1:0] e_dly  [TRIG_LATENCY];
  logic signed [SAMPLE_W-1:0] i_dly  [TRIG_LATENCY];

  state_t            state;
  logic [DEAD_W-1:0] dead_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic              accept;
  logic              drop;
  event_t            cap_evt;
  event_t            head_evt;

  // Crossing counter and the matching delay lines; the last stage lines up with trigger.
  always_ff @(posedge clk) begin
    if (rst) begin
      bx <= '0;
      for (int k = 0; k < TRIG_LATENCY; k++) begin
        bx_dly[k] <= '0;
        e_dly[k]  <= '0;
        i_dly[k]  <= '0;
      end
    end else begin
      bx        <= bx + 1'b1;
      bx_dly[0] <= bx;
      e_dly[0]  <= energy;
      i_dly[0]  <= isol;
      for (int k = 1; k < TRIG_LATENCY; k++) begin
        bx_dly[k] <= bx_dly[k-1];
        e_dly[k]  <= e_dly[k-1];
        i_dly[k]  <= i_dly[k-1];
      end
    end
  end

  assign cap_evt = {bx_dly[TRIG_LATENCY-1], e_dly[TRIG_LATENCY-1], i_dly[TRIG_LATENCY-1]};
  assign accept  = trigger & (state == ARMED) & ~fifo_full;
  assign drop    = trigger & (state == ARMED) & fifo_full;
  assign busy    = (state == DEAD) | fifo_full;

  // Dead-time FSM: an accept blocks the next DEAD_CYCLES triggers; drops never start dead time.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARMED;
      dead_cnt <= '0;
    end else begin
      case (state)
        ARMED: begin
          if (accept && (DEAD_CYCLES > 0)) begin
            state    <= DEAD;
            dead_cnt <= DEAD_W'(DEAD_CYCLES);
          end
        end
        DEAD: begin
          dead_cnt <= dead_cnt - 1'b1;
          if (dead_cnt <= 1) state <= ARMED;
        end
        default: state <= ARMED;
      endcase
    end
  end

  // Accept counter wraps, drop counter saturates, overflow stays set until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      accept_count <= '0;
      drop_count   <= '0;
      overflow     <= 1'b0;
    end else begin
      if (accept) accept_count <= accept_count + 1'b1;
      if (drop) begin
        drop_count <= sat_inc(drop_count);
        overflow   <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (EVENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (accept),
    .wr_dat (cap_evt),
    .rd_rdy (out_ready),
    .rd_dat (head_evt),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign out_valid  = ~fifo_empty;
  assign out_bx     = head_evt.bx;
  assign out_energy = head_evt.energy;
  assign out_isol   = head_evt.isol;

endmodule
